// File: rtl/h_alpha_stream_tx.sv
// Frame source for the decoder datapath: buffers I parity-check rows and A alpha
// columns, then streams every H row followed by every alpha column on two valid/ready/last channels.
module h_alpha_stream_tx #(
    parameter int J         = 14,
    parameter int I         = 7,
    parameter int A         = 2,
    parameter int DATAWIDTH = 8,
    parameter int ADDR_W    = $clog2((I > A) ? I : A) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic                   cfg_sel,
    input  logic [ADDR_W-1:0]      cfg_addr,
    input  logic [J*DATAWIDTH-1:0] cfg_wdata,
    output logic                   cfg_err,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [J-1:0]           H_row,
    output logic                   H_row_tvalid,
    output logic                   H_row_tlast,
    input  logic                   H_row_tready,
    output logic [J*DATAWIDTH-1:0] alpha_u_col,
    output logic                   alpha_u_col_tvalid,
    output logic                   alpha_u_col_tlast,
    input  logic                   alpha_u_col_tready
);

    localparam int COLW = J * DATAWIDTH;
    localparam int HIW  = (I > 1) ? $clog2(I) : 1;
    localparam int AIW  = (A > 1) ? $clog2(A) : 1;
    localparam logic [ADDR_W-1:0] H_NUM  = ADDR_W'(I);
    localparam logic [ADDR_W-1:0] A_NUM  = ADDR_W'(A);
    localparam logic [ADDR_W-1:0] H_LAST = ADDR_W'(I - 1);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(A - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND_H,
        SEND_A,
        FIN
    } state_t;

    state_t state;
    state_t state_d;

    logic [J-1:0]    h_mem [I];
    logic [COLW-1:0] a_mem [A];

    logic [ADDR_W-1:0] h_cnt;
    logic [ADDR_W-1:0] a_cnt;
    logic [ADDR_W-1:0] h_cnt_d;
    logic [ADDR_W-1:0] a_cnt_d;
    logic              h_valid_d;
    logic              a_valid_d;
    logic              busy_d;
    logic              done_d;
    logic              load_h;
    logic              load_a;

    logic              wr_legal;
    logic              wr_err;
    logic              start_go;
    logic              h_fire;
    logic              a_fire;

    logic              save_valid;
    logic              save_sel;
    logic [ADDR_W-1:0] save_addr;
    logic [COLW-1:0]   save_data;
    logic [COLW-1:0]   old_data;
    logic [J-1:0]      h_rd;
    logic [COLW-1:0]   a_rd;

    always_comb begin
        wr_legal = 1'b0;
        if (cfg_we && !busy) begin
            wr_legal = cfg_sel ? (cfg_addr < A_NUM) : (cfg_addr < H_NUM);
        end
        wr_err   = cfg_we && !wr_legal;
        start_go = (state == IDLE) && start;
        h_fire   = H_row_tvalid && H_row_tready;
        a_fire   = alpha_u_col_tvalid && alpha_u_col_tready;
    end

    assign H_row_tlast       = H_row_tvalid && (h_cnt == H_LAST);
    assign alpha_u_col_tlast = alpha_u_col_tvalid && (a_cnt == A_LAST);

    always_comb begin
        state_d   = state;
        h_cnt_d   = h_cnt;
        a_cnt_d   = a_cnt;
        h_valid_d = H_row_tvalid;
        a_valid_d = alpha_u_col_tvalid;
        busy_d    = busy;
        done_d    = 1'b0;
        load_h    = 1'b0;
        load_a    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d   = SEND_H;
                    h_cnt_d   = '0;
                    h_valid_d = 1'b1;
                    busy_d    = 1'b1;
                    load_h    = 1'b1;
                end
            end
            SEND_H: begin
                if (h_fire) begin
                    if (h_cnt == H_LAST) begin
                        state_d   = SEND_A;
                        h_cnt_d   = '0;
                        h_valid_d = 1'b0;
                        a_cnt_d   = '0;
                        a_valid_d = 1'b1;
                        load_a    = 1'b1;
                    end else begin
                        h_cnt_d = h_cnt + 1'b1;
                        load_h  = 1'b1;
                    end
                end
            end
            SEND_A: begin
                if (a_fire) begin
                    if (a_cnt == A_LAST) begin
                        state_d   = FIN;
                        a_cnt_d   = '0;
                        a_valid_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        a_cnt_d = a_cnt + 1'b1;
                        load_a  = 1'b1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A write landing together with start changes memory, so the overwritten
    // entry is kept aside and substituted whenever this frame reads it.
    always_comb begin
        old_data = cfg_sel ? a_mem[cfg_addr[AIW-1:0]]
                           : COLW'(h_mem[cfg_addr[HIW-1:0]]);
        h_rd = h_mem[h_cnt_d[HIW-1:0]];
        if ((state != IDLE) && save_valid && !save_sel && (save_addr == h_cnt_d)) begin
            h_rd = save_data[J-1:0];
        end
        a_rd = a_mem[a_cnt_d[AIW-1:0]];
        if ((state != IDLE) && save_valid && save_sel && (save_addr == a_cnt_d)) begin
            a_rd = save_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < I; k++) begin
                h_mem[k] <= '0;
            end
            for (int k = 0; k < A; k++) begin
                a_mem[k] <= '0;
            end
        end else if (wr_legal) begin
            if (cfg_sel) begin
                a_mem[cfg_addr[AIW-1:0]] <= cfg_wdata;
            end else begin
                h_mem[cfg_addr[HIW-1:0]] <= cfg_wdata[J-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt              <= '0;
            a_cnt              <= '0;
            H_row_tvalid       <= 1'b0;
            alpha_u_col_tvalid <= 1'b0;
            H_row              <= '0;
            alpha_u_col        <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            cfg_err            <= 1'b0;
            save_valid         <= 1'b0;
            save_sel           <= 1'b0;
            save_addr          <= '0;
            save_data          <= '0;
        end else begin
            h_cnt              <= h_cnt_d;
            a_cnt              <= a_cnt_d;
            H_row_tvalid       <= h_valid_d;
            alpha_u_col_tvalid <= a_valid_d;
            busy               <= busy_d;
            done               <= done_d;
            cfg_err            <= wr_err;
            if (load_h) begin
                H_row <= h_rd;
            end
            if (load_a) begin
                alpha_u_col <= a_rd;
            end
            if (start_go) begin
                save_valid <= wr_legal;
                save_sel   <= cfg_sel;
                save_addr  <= cfg_addr;
                save_data  <= old_data;
            end
        end
    end

endmodule

// File: tb/tb_h_alpha_stream_tx.sv
// Self-checking bench for h_alpha_stream_tx: config-write vector table, directed frame
// sequences and randomized frames checked against a beat-index model of the frame.
module tb_h_alpha_stream_tx;

    localparam int J    = 14;
    localparam int I    = 7;
    localparam int A    = 2;
    localparam int DW   = 8;
    localparam int AW   = $clog2((I > A) ? I : A) + 1;
    localparam int WB   = J * DW;
    localparam int MAXC = 200;

    typedef struct {
        logic          we;
        logic          sel;
        logic [AW-1:0] addr;
        logic [WB-1:0] wdata;
        logic          exp_err;
    } cfg_vec_t;

    logic          clk;
    logic          rst;
    logic          cfg_we;
    logic          cfg_sel;
    logic [AW-1:0] cfg_addr;
    logic [WB-1:0] cfg_wdata;
    logic          cfg_err;
    logic          start;
    logic          busy;
    logic          done;
    logic [J-1:0]  H_row;
    logic          H_row_tvalid;
    logic          H_row_tlast;
    logic          H_row_tready;
    logic [WB-1:0] alpha_u_col;
    logic          alpha_u_col_tvalid;
    logic          alpha_u_col_tlast;
    logic          alpha_u_col_tready;

    h_alpha_stream_tx #(
        .J(J), .I(I), .A(A), .DATAWIDTH(DW), .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_we(cfg_we),
        .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata),
        .cfg_err(cfg_err),
        .start(start),
        .busy(busy),
        .done(done),
        .H_row(H_row),
        .H_row_tvalid(H_row_tvalid),
        .H_row_tlast(H_row_tlast),
        .H_row_tready(H_row_tready),
        .alpha_u_col(alpha_u_col),
        .alpha_u_col_tvalid(alpha_u_col_tvalid),
        .alpha_u_col_tlast(alpha_u_col_tlast),
        .alpha_u_col_tready(alpha_u_col_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [J-1:0]  m_h [I];
    logic [WB-1:0] m_a [A];
    int            n_compared = 0;
    int            n_mismatch = 0;
    cfg_vec_t      vecs [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checkOutput(name, WB'(act), WB'(exp));
    endtask

    task automatic check_idle(input string tag);
        checkBit({tag, " h_valid"}, H_row_tvalid, 1'b0);
        checkBit({tag, " a_valid"}, alpha_u_col_tvalid, 1'b0);
        checkBit({tag, " busy"}, busy, 1'b0);
        checkBit({tag, " done"}, done, 1'b0);
    endtask

    task automatic check_reset(input string tag);
        check_idle(tag);
        checkOutput({tag, " h_row"}, WB'(H_row), '0);
        checkOutput({tag, " a_col"}, alpha_u_col, '0);
        checkBit({tag, " h_last"}, H_row_tlast, 1'b0);
        checkBit({tag, " a_last"}, alpha_u_col_tlast, 1'b0);
        checkBit({tag, " cfg_err"}, cfg_err, 1'b0);
    endtask

    function automatic logic addr_illegal(input logic sel, input logic [AW-1:0] addr);
        return sel ? (int'(addr) >= A) : (int'(addr) >= I);
    endfunction

    function automatic cfg_vec_t mk_vec(input logic we, input logic sel, input int addr,
                                        input logic [WB-1:0] wdata, input logic exp_err);
        cfg_vec_t v;
        v.we      = we;
        v.sel     = sel;
        v.addr    = AW'(addr);
        v.wdata   = wdata;
        v.exp_err = exp_err;
        return v;
    endfunction

    function automatic logic [WB-1:0] rand_col();
        logic [WB-1:0] col;
        for (int j = 0; j < J; j++) begin
            col[j*DW +: DW] = DW'($urandom);
        end
        return col;
    endfunction

    // One idle-time config write; the model memory follows only accepted writes.
    task automatic applyStimulus(input cfg_vec_t v);
        cfg_we    = v.we;
        cfg_sel   = v.sel;
        cfg_addr  = v.addr;
        cfg_wdata = v.wdata;
        tick();
        cfg_we = 1'b0;
        checkBit("cfg_err", cfg_err, v.exp_err);
        if (v.we && !v.exp_err) begin
            if (v.sel) begin
                m_a[int'(v.addr)] = v.wdata;
            end else begin
                m_h[int'(v.addr)] = v.wdata[J-1:0];
            end
        end
        tick();
        checkBit("cfg_err_clear", cfg_err, 1'b0);
    endtask

    task automatic random_load();
        cfg_vec_t v;
        for (int n = 0; n < 16; n++) begin
            v.we    = 1'b1;
            v.sel   = 1'($urandom_range(0, 1));
            v.addr  = v.sel ? AW'($urandom_range(0, A + 1)) : AW'($urandom_range(0, I + 1));
            v.wdata = rand_col();
            v.exp_err = addr_illegal(v.sel, v.addr);
            applyStimulus(v);
        end
    endtask

    // Frame model: beat index pos walks 0..I+A-1 (H rows then alpha columns),
    // advancing only when the active stream's ready is high; pos == I+A is the done cycle.
    task automatic run_frame(input string tag, input bit rnd, input logic [63:0] h_stall,
                             input logic [63:0] a_stall, input logic [63:0] start_mask,
                             input int busy_wr_cycle, input bit start_wr, input bit fin_start,
                             output int done_c);
        logic [J-1:0]  s_h [I];
        logic [WB-1:0] s_a [A];
        logic [AW-1:0] wa;
        logic [J-1:0]  wd;
        logic          hr;
        logic          ar;
        int            pos;
        int            h_rx;
        int            a_rx;
        bit            finished;
        done_c   = 0;
        finished = 0;
        check_idle({tag, " pre"});
        for (int k = 0; k < I; k++) s_h[k] = m_h[k];
        for (int k = 0; k < A; k++) s_a[k] = m_a[k];
        start = 1'b1;
        wa = '0;
        wd = '0;
        if (start_wr) begin
            wa        = AW'($urandom_range(0, I - 1));
            wd        = J'($urandom);
            cfg_we    = 1'b1;
            cfg_sel   = 1'b0;
            cfg_addr  = wa;
            cfg_wdata = WB'(wd);
        end
        tick();
        start  = 1'b0;
        cfg_we = 1'b0;
        if (start_wr) m_h[int'(wa)] = wd;
        pos  = 0;
        h_rx = 0;
        a_rx = 0;
        for (int c = 1; c <= MAXC; c++) begin
            checkBit({tag, " h_valid"}, H_row_tvalid, pos < I);
            checkBit({tag, " h_last"}, H_row_tlast, pos == I - 1);
            checkBit({tag, " a_valid"}, alpha_u_col_tvalid, (pos >= I) && (pos < I + A));
            checkBit({tag, " a_last"}, alpha_u_col_tlast, pos == I + A - 1);
            checkBit({tag, " busy"}, busy, pos < I + A);
            checkBit({tag, " done"}, done, pos == I + A);
            checkBit({tag, " cfg_err"}, cfg_err, (busy_wr_cycle > 0) && (c == busy_wr_cycle + 1));
            if (pos < I) checkOutput({tag, " h_row"}, WB'(H_row), WB'(s_h[pos]));
            if ((pos >= I) && (pos < I + A)) checkOutput({tag, " a_col"}, alpha_u_col, s_a[pos - I]);
            if (pos == I + A) begin
                checkOutput({tag, " h_rx_wrap"}, WB'(h_rx), '0);
                checkOutput({tag, " a_rx_wrap"}, WB'(a_rx), '0);
                done_c = c;
                start  = fin_start;
                tick();
                start = 1'b0;
                check_idle({tag, " post"});
                finished = 1;
                break;
            end
            hr = rnd ? ($urandom_range(0, 3) != 0) : ((c < 64) ? !h_stall[c] : 1'b1);
            ar = rnd ? ($urandom_range(0, 3) != 0) : ((c < 64) ? !a_stall[c] : 1'b1);
            H_row_tready       = hr;
            alpha_u_col_tready = ar;
            start = (c < 64) ? start_mask[c] : 1'b0;
            if (c == busy_wr_cycle) begin
                cfg_we    = 1'b1;
                cfg_sel   = 1'b0;
                cfg_addr  = AW'(1);
                cfg_wdata = '1;
            end
            if (H_row_tvalid && hr) h_rx = (h_rx == I - 1) ? 0 : h_rx + 1;
            if (alpha_u_col_tvalid && ar) a_rx = (a_rx == A - 1) ? 0 : a_rx + 1;
            if (pos < I) begin
                if (hr) pos++;
            end else if (hr || !hr) begin
                if (ar) pos++;
            end
            tick();
            start  = 1'b0;
            cfg_we = 1'b0;
        end
        if (!finished) begin
            n_compared++;
            n_mismatch++;
            $display("[TB] FAIL %s timeout: got no done within %0d cycles, expected done", tag, MAXC);
        end
        H_row_tready       = 1'b1;
        alpha_u_col_tready = 1'b1;
    endtask

    initial begin
        int dc;
        rst                = 1'b1;
        cfg_we             = 1'b0;
        cfg_sel            = 1'b0;
        cfg_addr           = '0;
        cfg_wdata          = '0;
        start              = 1'b0;
        H_row_tready       = 1'b1;
        alpha_u_col_tready = 1'b1;
        for (int k = 0; k < I; k++) m_h[k] = '0;
        for (int k = 0; k < A; k++) m_a[k] = '0;

        for (int k = 0; k < I; k++) vecs[k] = mk_vec(1'b1, 1'b0, k, WB'(14'(1) << k), 1'b0);
        vecs[7]  = mk_vec(1'b1, 1'b1, 0, {J{8'h11}}, 1'b0);
        vecs[8]  = mk_vec(1'b1, 1'b1, 1, {J{8'h22}}, 1'b0);
        vecs[9]  = mk_vec(1'b1, 1'b0, 7, WB'(14'h3FFF), 1'b1);
        vecs[10] = mk_vec(1'b1, 1'b0, 8, WB'(14'h2AAA), 1'b1);
        vecs[11] = mk_vec(1'b1, 1'b1, 2, {J{8'hEE}}, 1'b1);
        vecs[12] = mk_vec(1'b1, 1'b0, 15, WB'(14'h1555), 1'b1);
        vecs[13] = mk_vec(1'b0, 1'b0, 9, WB'(14'h0F0F), 1'b0);

        repeat (3) tick();
        rst = 1'b0;
        check_reset("reset");

        for (int n = 0; n < 14; n++) applyStimulus(vecs[n]);

        run_frame("plan_full", 0, 64'h0, 64'h0, 64'h0, 0, 0, 0, dc);
        checkOutput("plan_full done_cycle", WB'(dc), WB'(I + A + 1));
        run_frame("plan_stall", 0, 64'h38, 64'h0, 64'h0, 0, 0, 0, dc);
        checkOutput("plan_stall done_cycle", WB'(dc), WB'(I + A + 1 + 3));
        run_frame("plan_restart", 0, 64'h0, 64'h0, 64'h10, 5, 0, 1, dc);
        checkOutput("plan_restart done_cycle", WB'(dc), WB'(I + A + 1));
        run_frame("plan_after_busy_wr", 0, 64'h0, 64'h0, 64'h0, 0, 0, 0, dc);

        check_idle("rst_mid pre");
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (I + 1) tick();
        checkBit("rst_mid a_valid", alpha_u_col_tvalid, 1'b1);
        checkBit("rst_mid a_last", alpha_u_col_tlast, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("rst_mid");
        repeat (4) begin
            tick();
            check_idle("rst_mid quiet");
        end
        for (int k = 0; k < I; k++) m_h[k] = '0;
        for (int k = 0; k < A; k++) m_a[k] = '0;
        run_frame("zero_frame", 0, 64'h0, 64'h0, 64'h0, 0, 0, 0, dc);
        for (int n = 0; n < 14; n++) applyStimulus(vecs[n]);
        run_frame("reloaded", 0, 64'h0, 64'h0, 64'h0, 0, 0, 0, dc);

        repeat (3) begin
            random_load();
            run_frame("rand", 1, 64'h0, 64'h0, 64'h0, 0, 1'($urandom_range(0, 1)), 0, dc);
        end
        random_load();
        for (int f = 0; f < 3; f++) begin
            run_frame("b2b", 1, 64'h0, 64'h0, 64'h0, 0, 1, 0, dc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
